// File: rtl/multi_interval_timer.sv
// multi_interval_timer: NUM_CH down-counting interval timers on one Avalon-MM slave.
// All channels share one prescaler. Each channel has one-shot/continuous mode, an irq enable,
// a snapshot register and a one-cycle timeout pulse.
//
// Bus semantics: this slave has no waitrequest. A write is accepted on every clk edge
// where chipselect & ~write_n is high. readdata is registered every cycle from the
// address mux, so it shows the register selected by the address of the previous cycle.
// chipselect and read_n do not gate it, and reads have no side effects.
module multi_interval_timer #(
  parameter int          NUM_CH     = 2,
  parameter int          COUNT_W    = 32,
  parameter int unsigned PERIOD_RST = 4999999,
  parameter int          PRESC_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic              read_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq,
  output logic [NUM_CH-1:0] timeout_pulse
);

  localparam logic [COUNT_W-1:0] PERIOD_INIT   = COUNT_W'(PERIOD_RST);
  localparam logic [4:0]         ADDR_PRESCALE = 5'd28;
  localparam logic [4:0]         ADDR_IRQSUM   = 5'd29;

  logic                wr;
  logic                wr_presc;
  logic                tick;
  logic [PRESC_W-1:0]  prescale_q;
  logic [PRESC_W-1:0]  presc_cnt_q;

  logic [COUNT_W-1:0]  count_q  [NUM_CH];
  logic [COUNT_W-1:0]  period_q [NUM_CH];
  logic [COUNT_W-1:0]  snap_q   [NUM_CH];
  logic [NUM_CH-1:0]   to_q;
  logic [NUM_CH-1:0]   run_q;
  logic [NUM_CH-1:0]   ito_q;
  logic [NUM_CH-1:0]   cont_q;
  logic [NUM_CH-1:0]   irq_vec;

  logic [NUM_CH-1:0]   wr_status;
  logic [NUM_CH-1:0]   wr_control;
  logic [NUM_CH-1:0]   wr_period;
  logic [NUM_CH-1:0]   wr_snap;
  logic [31:0]         rd_mux;

  // read_n has no side effects, and the upper writedata bits beyond COUNT_W are not stored
  logic unused_bits;
  assign unused_bits = ^{read_n, writedata};

  assign wr       = chipselect & ~write_n;
  assign wr_presc = wr && (address == ADDR_PRESCALE);
  assign tick     = (presc_cnt_q == prescale_q);
  assign irq_vec  = to_q & ito_q;
  assign irq      = |irq_vec;

  // Decode a bus write into per-channel register strobes.
  // Addresses 28..31 give address[4:2]==7, which no channel index can reach.
  always_comb begin
    wr_status  = '0;
    wr_control = '0;
    wr_period  = '0;
    wr_snap    = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (wr && (address[4:2] == 3'(c))) begin
        case (address[1:0])
          2'd0:    wr_status[c]  = 1'b1;
          2'd1:    wr_control[c] = 1'b1;
          2'd2:    wr_period[c]  = 1'b1;
          default: wr_snap[c]    = 1'b1;
        endcase
      end
    end
  end

  // Shared prescaler: counts 0..PRESCALE, tick on the terminal count; a PRESCALE write restarts it
  always_ff @(posedge clk) begin
    if (reset) begin
      prescale_q  <= '0;
      presc_cnt_q <= '0;
    end else if (wr_presc) begin
      prescale_q  <= writedata[PRESC_W-1:0];
      presc_cnt_q <= '0;
    end else if (tick) begin
      presc_cnt_q <= '0;
    end else begin
      presc_cnt_q <= presc_cnt_q + PRESC_W'(1);
    end
  end

  // Channel state. Later assignments win, which encodes the priority:
  // PERIOD write > START > STOP > auto-stop, and a timeout beats a STATUS clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        count_q[c]  <= PERIOD_INIT;
        period_q[c] <= PERIOD_INIT;
        snap_q[c]   <= '0;
      end
      to_q          <= '0;
      run_q         <= '0;
      ito_q         <= '0;
      cont_q        <= '0;
      timeout_pulse <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        timeout_pulse[c] <= 1'b0;
        if (wr_status[c]) to_q[c] <= 1'b0;
        if (tick && run_q[c]) begin
          if (count_q[c] == '0) begin
            count_q[c]       <= period_q[c];
            to_q[c]          <= 1'b1;
            timeout_pulse[c] <= 1'b1;
            if (!cont_q[c]) run_q[c] <= 1'b0;
          end else begin
            count_q[c] <= count_q[c] - COUNT_W'(1);
          end
        end
        // The snapshot samples the registered count, i.e. the pre-decrement value
        if (wr_snap[c]) snap_q[c] <= count_q[c];
        if (wr_control[c]) begin
          ito_q[c]  <= writedata[0];
          cont_q[c] <= writedata[1];
          if (writedata[2])      run_q[c] <= 1'b1;
          else if (writedata[3]) run_q[c] <= 1'b0;
        end
        if (wr_period[c]) begin
          period_q[c] <= writedata[COUNT_W-1:0];
          count_q[c]  <= writedata[COUNT_W-1:0];
          run_q[c]    <= 1'b0;
        end
      end
    end
  end

  // Read mux; absent channels and unmapped addresses return 0
  always_comb begin
    rd_mux = '0;
    if (address == ADDR_PRESCALE) begin
      rd_mux = 32'(prescale_q);
    end else if (address == ADDR_IRQSUM) begin
      rd_mux = 32'(irq_vec);
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (address[4:2] == 3'(c)) begin
          case (address[1:0])
            2'd0:    rd_mux = {30'b0, run_q[c], to_q[c]};
            2'd1:    rd_mux = {30'b0, cont_q[c], ito_q[c]};
            2'd2:    rd_mux = 32'(period_q[c]);
            default: rd_mux = 32'(snap_q[c]);
          endcase
        end
      end
    end
  end

  // Registered read data, refreshed every cycle
  always_ff @(posedge clk) begin
    if (reset) readdata <= '0;
    else       readdata <= rd_mux;
  end

endmodule
